// File: rtl/physics_sweep_scheduler_if.sv
// Bundle of load, datapath and committed-state signals between the physics
// sweep scheduler (slave) and whoever drives it (master).
interface physics_sweep_scheduler_if #(
    parameter int SPRITES    = 9,
    parameter int DIMENSIONS = 2,
    parameter int WIDTH      = 32
);
    localparam int IDX_W = $clog2(SPRITES);

    logic                                        data_ready;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] init_locations;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] init_velos;
    logic [DIMENSIONS-1:0][WIDTH-1:0]             calc_locations_in;
    logic [DIMENSIONS-1:0][WIDTH-1:0]             calc_velos_in;
    logic [IDX_W-1:0]                             sprite_index;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] locations;
    logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] velos;
    logic                                        frame_done;
    logic                                        busy;
    logic                                        overrun;

    modport master (
        output data_ready, init_locations, init_velos, calc_locations_in, calc_velos_in,
        input  sprite_index, locations, velos, frame_done, busy, overrun
    );

    modport slave (
        input  data_ready, init_locations, init_velos, calc_locations_in, calc_velos_in,
        output sprite_index, locations, velos, frame_done, busy, overrun
    );
endinterface

// File: rtl/physics_sweep_scheduler.sv
// Steps sprite_index across all sprites, captures the calc datapath result into
// shadow registers and commits the whole snapshot atomically on the frame tick.
module physics_sweep_scheduler #(
    parameter int SPRITES       = 9,
    parameter int DIMENSIONS    = 2,
    parameter int WIDTH         = 32,
    parameter int FRAME_CYCLES  = 2_700_000,
    parameter int SETTLE_CYCLES = 65536
) (
    input  logic                    clk_162,
    input  logic                    rst_l,
    physics_sweep_scheduler_if.slave bus
);
    localparam int IDX_W    = $clog2(SPRITES);
    localparam int FRAME_W  = (FRAME_CYCLES  > 1) ? $clog2(FRAME_CYCLES)  : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [IDX_W-1:0]    LAST_SPRITE = IDX_W'(SPRITES - 1);
    localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT_TICK} state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [FRAME_W-1:0]  frame_cnt_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [IDX_W-1:0]    sprite_index_reg;
    logic                frame_done_reg;
    logic                overrun_reg;

    logic load;
    logic tick;
    logic last_sprite;
    logic busy;
    logic do_capture;
    logic do_commit;

    assign load        = bus.data_ready;
    assign tick        = (state_reg != IDLE) && (frame_cnt_reg == FRAME_LAST);
    assign last_sprite = (sprite_index_reg == LAST_SPRITE);

    always_ff @(posedge clk_162) begin
        if (!rst_l) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = SETTLE;
        end else begin
            case (state_reg)
                SETTLE:    if (settle_cnt_reg == SETTLE_LAST) state_next = CAPTURE;
                CAPTURE:   state_next = last_sprite ? WAIT_TICK : SETTLE;
                WAIT_TICK: if (tick) state_next = SETTLE;
                default:   state_next = state_reg;
            endcase
        end
    end

    // A load in the same cycle wins over capture and commit.
    always_comb begin
        busy       = 1'b0;
        do_capture = 1'b0;
        do_commit  = 1'b0;
        case (state_reg)
            SETTLE:    busy = 1'b1;
            CAPTURE: begin
                busy       = 1'b1;
                do_capture = !load;
            end
            WAIT_TICK: do_commit = tick && !load;
            default:   busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk_162) begin
        if (!rst_l) begin
            frame_cnt_reg    <= '0;
            settle_cnt_reg   <= '0;
            sprite_index_reg <= '0;
            frame_done_reg   <= 1'b0;
            overrun_reg      <= 1'b0;
        end else if (load) begin
            frame_cnt_reg    <= '0;
            settle_cnt_reg   <= '0;
            sprite_index_reg <= '0;
            frame_done_reg   <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            frame_done_reg <= do_commit;
            if (state_reg != IDLE) begin
                frame_cnt_reg <= tick ? '0 : frame_cnt_reg + FRAME_W'(1);
            end
            if (state_reg == SETTLE && settle_cnt_reg != SETTLE_LAST) begin
                settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
            end else begin
                settle_cnt_reg <= '0;
            end
            if (do_capture && !last_sprite) begin
                sprite_index_reg <= sprite_index_reg + IDX_W'(1);
            end else if (do_commit) begin
                sprite_index_reg <= '0;
            end
            if (tick && busy) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Per-sprite shadow and committed state; only the selected sprite captures.
    genvar gi;
    generate
        for (gi = 0; gi < SPRITES; gi++) begin : g_sprite
            logic [DIMENSIONS-1:0][WIDTH-1:0] shadow_loc_reg;
            logic [DIMENSIONS-1:0][WIDTH-1:0] shadow_vel_reg;
            logic [DIMENSIONS-1:0][WIDTH-1:0] loc_reg;
            logic [DIMENSIONS-1:0][WIDTH-1:0] vel_reg;
            logic                             capture_here;

            assign capture_here = do_capture && (sprite_index_reg == IDX_W'(gi));

            always_ff @(posedge clk_162) begin
                if (!rst_l) begin
                    shadow_loc_reg <= '0;
                    shadow_vel_reg <= '0;
                    loc_reg        <= '0;
                    vel_reg        <= '0;
                end else if (load) begin
                    shadow_loc_reg <= '0;
                    shadow_vel_reg <= '0;
                    loc_reg        <= bus.init_locations[gi];
                    vel_reg        <= bus.init_velos[gi];
                end else begin
                    if (capture_here) begin
                        shadow_loc_reg <= bus.calc_locations_in;
                        shadow_vel_reg <= bus.calc_velos_in;
                    end
                    if (do_commit) begin
                        loc_reg <= shadow_loc_reg;
                        vel_reg <= shadow_vel_reg;
                    end
                end
            end

            assign bus.locations[gi] = loc_reg;
            assign bus.velos[gi]     = vel_reg;
        end
    endgenerate

    assign bus.sprite_index = sprite_index_reg;
    assign bus.frame_done   = frame_done_reg;
    assign bus.busy         = busy;
    assign bus.overrun      = overrun_reg;
endmodule

// File: doc/physics_sweep_scheduler.md
# physics_sweep_scheduler

Frame scheduler for the shared per-sprite `calc` datapath of the physics engine. Each frame it steps `sprite_index` through every sprite, holds each index for a fixed settle window while the combinational divider chain resolves, and captures the datapath result into shadow registers. On the frame tick it commits all shadow state at once, so the renderer only ever sees a consistent snapshot. It replaces the ad-hoc counter and `sprite_index` logic inside `physics_engine`.

## Interface
- `SPRITES`, 9, number of sprites; must be ≥2.
- `DIMENSIONS`, 2, axes per sprite.
- `WIDTH`, 32, fixed-point word width.
- `FRAME_CYCLES`, 2_700_000, clock cycles per frame (60 Hz at 162 MHz).
- `SETTLE_CYCLES`, 65536, cycles each index is held before capture; must be ≥1.

Ports:
- `clk_162` in 1: sole clock.
- `rst_l` in 1: reset, synchronous, active-low.
- `data_ready` in 1: load-initial-state strobe, sampled every cycle.
- `init_locations`, `init_velos` in [SPRITES][DIMENSIONS][WIDTH]: initial state.
- `calc_locations_in`, `calc_velos_in` in [DIMENSIONS][WIDTH]: result of the `calc` datapath for the current `sprite_index`.
- `sprite_index` out [$clog2(SPRITES)]: selects the sprite the datapath works on.
- `locations`, `velos` out [SPRITES][DIMENSIONS][WIDTH]: committed state, fed back to the datapath and the renderer.
- `frame_done` out 1: one-cycle pulse in the first cycle that a new commit is visible.
- `busy` out 1: high while a sweep is in progress (SETTLE or CAPTURE).
- `overrun` out 1: sticky flag, a frame tick arrived before the sweep finished.

## Operation
- States: IDLE, SETTLE, CAPTURE, WAIT_TICK.
- Reset: state IDLE. All of the following are 0: `locations`, `velos`, shadow registers, `sprite_index`, `frame_cnt`, `settle_cnt`, `frame_done`, `busy`, `overrun`.
- `data_ready` has top priority in every state, including mid-sweep. On the next edge:
  - `locations` and `velos` load from the init inputs.
  - Shadow registers clear.
  - `frame_cnt`, `settle_cnt`, `sprite_index` and `overrun` clear to 0.
  - State goes to SETTLE.
- IDLE: holds all outputs. `frame_cnt` is stopped.
- SETTLE: `settle_cnt` increments each cycle. When `settle_cnt` == SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - Shadow[`sprite_index`] takes `calc_*_in`.
  - If `sprite_index` == SPRITES-1, go to WAIT_TICK.
  - Otherwise `sprite_index` increments, `settle_cnt` clears to 0, and state returns to SETTLE.
- `frame_cnt` runs whenever the state is not IDLE and wraps at FRAME_CYCLES-1 back to 0. The tick is the cycle where `frame_cnt` == FRAME_CYCLES-1.
- Tick in WAIT_TICK (commit):
  - `locations` and `velos` take the shadow values.
  - `frame_done` is high for the following cycle.
  - `sprite_index` and `settle_cnt` clear to 0; state goes to SETTLE.
- Tick in SETTLE or CAPTURE:
  - `overrun` is set to 1; there is no commit and no `frame_done`.
  - The sweep continues unchanged and commits at the next tick reached in WAIT_TICK.
- Tick coinciding with `data_ready`: the load wins; no commit, no overrun.
- `locations` and `velos` are stable throughout a sweep; they change only on commit or load.
- Arithmetic: the block does no data arithmetic. Data is copied unmodified at full WIDTH.

## Timing
- `data_ready` sampled high at cycle T:
  - At T+1: new `locations` visible, `sprite_index`=0, `frame_cnt`=0, `busy`=1.
- Sprite k (S = SETTLE_CYCLES, N = SPRITES, F = FRAME_CYCLES):
  - Captured in CAPTURE cycle T+1+k(S+1)+S.
  - `sprite_index`=k+1 visible from T+(k+1)(S+1)+1.
- Sweep length is N(S+1) cycles. `busy` falls at T+N(S+1)+1.
- The first commit is visible at T+F+1, when `frame_done` is also high. Later commits follow at an exact period of F.
- The datapath must be valid within S cycles of a `sprite_index` change.
- Overrun-free operation requires N(S+1) < F.

## Test plan
Bench parameters: SPRITES=3, SETTLE_CYCLES=4, FRAME_CYCLES=64.

1. Reset with `rst_l`=0 for 2 cycles while `data_ready`=1 and inputs are nonzero -> all outputs stay 0 and state stays IDLE; no load occurs.
2. `data_ready` pulse at T with `init_locations[1][0]`=32'h0001_0000 -> at T+1, `locations[1][0]` = that value. `sprite_index` reads 0 at T+1, 1 at T+6 and 2 at T+11. Captures happen at T+5, T+10 and T+15. `busy` falls at T+16.
3. Drive `calc_locations_in` = {sprite_index, 28'h0}+1 -> at T+65, `locations[k][*]` reflects sprite k's value and `frame_done` is high for exactly one cycle. The next `frame_done` is at T+129.
4. Bench with FRAME_CYCLES=12 -> tick at T+12 mid-sweep. `overrun`=1 at T+13; `locations` are unchanged and there is no `frame_done`. The commit becomes visible at T+25.
5. `data_ready` re-asserted at T+8, in the middle of sprite 1 -> at T+9, `sprite_index`=0, `overrun`=0 and shadow is cleared. The capture schedule restarts relative to T+8.
6. `rst_l` low during WAIT_TICK -> at the next cycle all outputs are 0 and state is IDLE. No `frame_done` occurs until a new `data_ready`.
